// File: rtl/gmm_pixel_scheduler.sv
// Per-pixel sequencer in front of the GMM fitgaussian datapath: accepts one
// grey pixel at a time, drives the model-memory addresses, fires the fit,
// waits for completion (with timeout) and emits one foreground bit per pixel.
module gmm_pixel_scheduler #(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned READ_LAT     = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [31:0]       pix_grey,
  output logic [31:0]       grey,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] waddr,
  output logic              first_frame,
  output logic              en_fitgaussian,
  input  logic              rd_fitgassian,
  input  logic              isFit,
  output logic              fg_valid,
  input  logic              fg_ready,
  output logic              fg_bit,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_timeout,
  output logic              err_sync
);

  localparam int unsigned       LAT_W     = $clog2(READ_LAT + 2);
  localparam int unsigned       TO_W      = $clog2(TIMEOUT + 2);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = (READ_LAT > 0) ? LAT_W'(READ_LAT - 1) : '0;
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FIRE,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [LAT_W-1:0]   lat_cnt;
  logic [TO_W-1:0]    to_cnt;

  // The pixel counter only moves at accept (SOF realign) or at the EMIT
  // handshake, so both addresses stay stable for the whole pixel.
  assign raddr = addr;
  assign waddr = addr;

  // Pixel sequencing FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      addr           <= '0;
      lat_cnt        <= '0;
      to_cnt         <= '0;
      pix_ready      <= 1'b0;
      grey           <= '0;
      first_frame    <= 1'b1;
      en_fitgaussian <= 1'b0;
      fg_valid       <= 1'b0;
      fg_bit         <= 1'b0;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      err_timeout    <= 1'b0;
      err_sync       <= 1'b0;
    end else begin
      en_fitgaussian <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        S_IDLE: begin
          pix_ready <= 1'b1;
          if (pix_valid && pix_ready) begin
            pix_ready <= 1'b0;
            grey      <= pix_grey;
            if (pix_sof) begin
              addr <= '0;
              if (addr != '0) err_sync <= 1'b1;
            end
            lat_cnt <= LAT_LOAD;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (lat_cnt == '0) state <= S_FIRE;
          else               lat_cnt <= lat_cnt - LAT_W'(1);
        end
        S_FIRE: begin
          en_fitgaussian <= 1'b1;
          to_cnt         <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_fitgassian) begin
            fg_bit   <= ~isFit;
            fg_valid <= 1'b1;
            state    <= S_EMIT;
          end else if (to_cnt == TO_LIMIT) begin
            err_timeout <= 1'b1;
            fg_bit      <= 1'b1;
            fg_valid    <= 1'b1;
            state       <= S_EMIT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_EMIT: begin
          if (fg_ready) begin
            fg_valid  <= 1'b0;
            pix_ready <= 1'b1;
            state     <= S_IDLE;
            if (addr == LAST_ADDR) begin
              addr        <= '0;
              frame_done  <= 1'b1;
              first_frame <= 1'b0;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmm_pixel_scheduler.sv
// Self-checking bench for gmm_pixel_scheduler: directed scenarios followed by
// randomized pixels, all compared against a per-pixel transaction model.
module tb_gmm_pixel_scheduler;

  localparam int unsigned FP = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned RL = 2;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic [31:0]   pix_grey;
  logic [31:0]   grey;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic          first_frame;
  logic          en_fitgaussian;
  logic          rd_fitgassian;
  logic          isFit;
  logic          fg_valid;
  logic          fg_ready;
  logic          fg_bit;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          err_timeout;
  logic          err_sync;

  gmm_pixel_scheduler #(
    .FRAME_PIXELS(FP),
    .ADDR_W      (AW),
    .READ_LAT    (RL),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_sof       (pix_sof),
    .pix_grey      (pix_grey),
    .grey          (grey),
    .raddr         (raddr),
    .waddr         (waddr),
    .first_frame   (first_frame),
    .en_fitgaussian(en_fitgaussian),
    .rd_fitgassian (rd_fitgassian),
    .isFit         (isFit),
    .fg_valid      (fg_valid),
    .fg_ready      (fg_ready),
    .fg_bit        (fg_bit),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .err_timeout   (err_timeout),
    .err_sync      (err_sync)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the scheduler's architectural state.
  int m_addr;
  bit m_ff;
  int m_fcnt;
  bit m_esync;
  bit m_eto;

  task automatic model_reset();
    m_addr  = 0;
    m_ff    = 1'b1;
    m_fcnt  = 0;
    m_esync = 1'b0;
    m_eto   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full pixel transaction. fit_lat < 0 means the fit never completes.
  task automatic pixel(input bit sof, input int fit_lat, input bit fit,
                       input int bp, input logic [31:0] g);
    int  a_use;
    int  k;
    bit  wrap;
    bit  exp_bit;
    k = 0;
    while (pix_ready !== 1'b1 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("pix_ready_wait", pix_ready, 1);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_grey  = g;
    a_use = sof ? 0 : m_addr;
    if (sof && m_addr != 0) m_esync = 1'b1;
    m_addr = a_use;
    @(negedge clk_i);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_grey  = $urandom;
    chk("grey", grey, g);
    chk("raddr_accept", raddr, a_use);
    chk("waddr_accept", waddr, a_use);
    chk("pix_ready_busy", pix_ready, 0);
    chk("first_frame", first_frame, m_ff);
    chk("err_sync", err_sync, m_esync);
    k = 0;
    while (en_fitgaussian !== 1'b1 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("en_latency", k, RL + 1);
    if (fit_lat >= 0) begin
      for (int j = 0; j < fit_lat; j++) begin
        @(negedge clk_i);
        chk("fg_valid_wait", fg_valid, 0);
      end
      rd_fitgassian = 1'b1;
      isFit         = fit;
      @(negedge clk_i);
      rd_fitgassian = 1'b0;
      isFit         = $urandom_range(0, 1);
      chk("en_width", en_fitgaussian, 0);
      exp_bit = ~fit;
    end else begin
      for (int j = 1; j <= int'(TO) + 1; j++) begin
        @(negedge clk_i);
        if (j == 1) chk("en_width", en_fitgaussian, 0);
        if (j == int'(TO)) begin
          chk("err_timeout_early", err_timeout, m_eto);
          chk("fg_valid_pre_to", fg_valid, 0);
        end
      end
      m_eto   = 1'b1;
      exp_bit = 1'b1;
      chk("err_timeout_set", err_timeout, 1);
    end
    chk("fg_valid", fg_valid, 1);
    chk("fg_bit", fg_bit, exp_bit);
    for (int j = 0; j < bp; j++) begin
      @(negedge clk_i);
      chk("bp_fg_valid", fg_valid, 1);
      chk("bp_fg_bit", fg_bit, exp_bit);
      chk("bp_pix_ready", pix_ready, 0);
      chk("bp_raddr", raddr, a_use);
      chk("bp_first_frame", first_frame, m_ff);
    end
    fg_ready = 1'b1;
    @(negedge clk_i);
    fg_ready = 1'b0;
    wrap = (a_use == int'(FP) - 1);
    if (wrap) begin
      m_addr = 0;
      m_ff   = 1'b0;
      if (m_fcnt < 65535) m_fcnt++;
    end else begin
      m_addr = a_use + 1;
    end
    chk("hs_fg_valid", fg_valid, 0);
    chk("hs_pix_ready", pix_ready, 1);
    chk("frame_done", frame_done, wrap);
    chk("frame_cnt", frame_cnt, m_fcnt);
    chk("hs_first_frame", first_frame, m_ff);
    chk("hs_raddr", raddr, m_addr);
    chk("hs_err_timeout", err_timeout, m_eto);
    chk("hs_err_sync", err_sync, m_esync);
    @(negedge clk_i);
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_i         = 1'b1;
    pix_valid     = 1'b0;
    pix_sof       = 1'b0;
    pix_grey      = '0;
    rd_fitgassian = 1'b0;
    isFit         = 1'b0;
    fg_ready      = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_first_frame", first_frame, 1);
    chk("rst_fg_valid", fg_valid, 0);
    chk("rst_en", en_fitgaussian, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_timeout, err_sync, frame_done, fg_bit}, 0);
    chk("rst_grey", grey, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_pix_ready", pix_ready, 1);

    // Frame 0: first pixel background-miss, then a full frame wrap
    pixel(1'b1, 5, 1'b0, 0, 32'h42C8_0000);
    pixel(1'b0, 0, 1'b1, 0, $urandom);
    pixel(1'b0, int'(TO) - 1, 1'b1, 10, $urandom);
    pixel(1'b0, 3, 1'b1, 2, $urandom);
    // Next frame starts at 0 without SOF: no error
    pixel(1'b0, 2, 1'b1, 0, $urandom);
    pixel(1'b0, 1, 1'b0, 0, $urandom);
    // SOF on the 3rd pixel realigns to 0 and flags err_sync
    pixel(1'b1, 4, 1'b0, 0, $urandom);
    pixel(1'b0, 2, 1'b1, 0, $urandom);
    // Timeout, then a late completion while idle
    pixel(1'b0, -1, 1'b0, 1, $urandom);
    rd_fitgassian = 1'b1;
    isFit         = 1'b0;
    @(negedge clk_i);
    rd_fitgassian = 1'b0;
    chk("late_rd_fg_valid", fg_valid, 0);
    chk("late_rd_en", en_fitgaussian, 0);
    chk("late_rd_pix_ready", pix_ready, 1);
    @(negedge clk_i);
    chk("late_rd_fg_valid2", fg_valid, 0);

    // Randomized pixels
    for (int n = 0; n < 40; n++) begin
      bit sof;
      int fl;
      sof = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      pixel(sof, fl, 1'(($urandom_range(0, 1))), int'($urandom_range(0, 3)), $urandom);
    end

    // Reset while waiting for the fit
    k = 0;
    while (pix_ready !== 1'b1 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    pix_valid = 1'b1;
    pix_grey  = $urandom;
    @(negedge clk_i);
    pix_valid = 1'b0;
    k = 0;
    while (en_fitgaussian !== 1'b1 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("rw_en_latency", k, RL + 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    chk("rw_fg_valid", fg_valid, 0);
    chk("rw_first_frame", first_frame, 1);
    chk("rw_frame_cnt", frame_cnt, 0);
    chk("rw_raddr", raddr, 0);
    chk("rw_errs", {err_timeout, err_sync}, 0);
    chk("rw_pix_ready_low", pix_ready, 0);
    @(negedge clk_i);
    chk("rw_pix_ready", pix_ready, 1);
    chk("rw_fg_valid2", fg_valid, 0);
    pixel(1'b0, 1, 1'b1, 0, $urandom);
    pixel(1'b0, 3, 1'b0, 1, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmm_pixel_scheduler.md
# gmm_pixel_scheduler

Per-pixel sequencer that sits upstream of the GMM `fitgaussian` datapath. It accepts a grey-level pixel stream and generates the model-memory read and write addresses. It holds the `first_frame` flag for frame 0, fires one `en_fitgaussian` pulse per pixel and waits for fit completion. It then emits one foreground/background bit per pixel on a valid/ready stream toward the background-model and blob stages.

## Interface
Parameters:
- `FRAME_PIXELS`, default 76800: pixels per frame (320x240); must be ≤ 2^ADDR_W.
- `ADDR_W`, default 18: width of the model-memory address.
- `READ_LAT`, default 2: cycles from `raddr` change to valid model data at the datapath inputs (1 cycle memory read plus 1 cycle input mux).
- `TIMEOUT`, default 255: maximum cycles spent waiting for fit completion.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `pix_valid` in 1: input pixel valid.
- `pix_ready` out 1: scheduler can accept a pixel.
- `pix_sof` in 1: qualifies the accepted pixel as the first of a frame.
- `pix_grey` in 32: IEEE-754 single-precision grey value.
- `grey` out 32: latched pixel value to the datapath.
- `raddr` out ADDR_W: model-memory read address.
- `waddr` out ADDR_W: model-memory write address.
- `first_frame` out 1: high for every pixel of frame 0.
- `en_fitgaussian` out 1: one-cycle start pulse.
- `rd_fitgassian` in 1: fit complete (coincides with the memory write-enable).
- `isFit` in 1: pixel matched a Gaussian.
- `fg_valid` out 1: result valid.
- `fg_ready` in 1: result accepted downstream.
- `fg_bit` out 1: 1 = foreground.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is emitted.
- `frame_cnt` out 16: completed frames, saturating at 0xFFFF.
- `err_timeout` out 1: sticky; set on timeout.
- `err_sync` out 1: sticky; set on SOF misalignment.

## Operation
The FSM has states IDLE, FETCH, FIRE, WAIT, EMIT.

- **IDLE**
  - `pix_ready` = 1.
  - On `pix_valid`, latch `pix_grey` into `grey`.
  - Drive `raddr` = `waddr` = `addr`, where `addr` is the internal pixel counter.
  - Load the latency counter with READ_LAT − 1 and go to FETCH.
- **FETCH**
  - Count down; at 0, go to FIRE.
  - If READ_LAT = 0, pass through FETCH in a single cycle.
- **FIRE**
  - `en_fitgaussian` = 1 for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - On `rd_fitgassian`, set `fg_bit` = !`isFit` and go to EMIT.
  - If `TIMEOUT` cycles elapse first: set `err_timeout`, set `fg_bit` = 1 (conservative foreground) and go to EMIT.
  - A late `rd_fitgassian` arriving in any other state is ignored.
- **EMIT**
  - `fg_valid` = 1, and it holds until `fg_ready`.
  - On the handshake: advance `addr`, then go to IDLE.
  - If `addr` = FRAME_PIXELS − 1:
    - `addr` wraps to 0.
    - `frame_done` pulses.
    - `frame_cnt` increments.
    - `first_frame` clears permanently. It is cleared after the handshake, so it stays high for the full last pixel of frame 0.

General rules:
- `grey`, `raddr` and `waddr` are held stable from accept until the EMIT handshake. The write issued with `rd_fitgassian` therefore lands at the correct address.
- **SOF handling:**
  - `pix_sof` accepted while `addr` ≠ 0: `addr` is forced to 0 for this pixel and `err_sync` is set.
  - `addr` = 0 accepted without `pix_sof`: no error.
- **Error clearing:**
  - Sticky errors clear only on reset.
  - A new accept does not clear them.

## Timing
Reset values:
- `pix_ready` = 0 during reset, 1 in the cycle after reset deasserts.
- All other outputs = 0, except `first_frame` = 1.
- `addr` = 0; state = IDLE.

Latency and throughput:
- Accept edge to `en_fitgaussian` high = READ_LAT + 1 cycles.
- `rd_fitgassian` edge to `fg_valid` high = 1 cycle.
- Exactly one pixel is in flight; throughput is one pixel per (READ_LAT + 3 + fit latency + backpressure) cycles.

Handshake rules:
- `pix_ready` is asserted only in IDLE.
- `fg_valid` must not drop until `fg_ready` is seen.
- `fg_bit` must not change while `fg_valid` is high.

Reset mid-operation:
- Any state returns to IDLE on the next edge.
- `addr` = 0 and `first_frame` = 1.
- Any pending `fg_valid` is dropped.

Width rules:
- `addr` compares against FRAME_PIXELS − 1 at ADDR_W bits.
- `frame_cnt` saturates at 0xFFFF and does not wrap.

## Test plan
- **Single pixel, frame 0.** Stimulus: reset, then `pix_valid` + `pix_sof` with grey = 0x42C80000 (100.0), READ_LAT = 2, `rd_fitgassian` 20 cycles after FIRE with `isFit` = 0. Required: `en_fitgaussian` pulses exactly at accept + 3; `first_frame` = 1; `fg_bit` = 1; `raddr` = `waddr` = 0 throughout.
- **Frame wrap.** Stimulus: FRAME_PIXELS = 4, stream 4 pixels with `isFit` = 1. Required: `fg_bit` = 0 ×4; `frame_done` pulses once after the 4th handshake; `frame_cnt` = 1; `first_frame` drops to 0 only then; 5th pixel uses `addr` 0.
- **Backpressure.** Stimulus: hold `fg_ready` = 0 for 10 cycles. Required: `fg_valid` and `fg_bit` stable; `pix_ready` = 0; `addr` unchanged; advance occurs only on the handshake cycle.
- **Timeout.** Stimulus: TIMEOUT = 8, never assert `rd_fitgassian`. Required: `err_timeout` = 1 at FIRE + 9; `fg_bit` = 1; a subsequent late `rd_fitgassian` in IDLE produces no `fg_valid`.
- **SOF misalignment.** Stimulus: assert `pix_sof` on the 3rd pixel of a frame. Required: `err_sync` = 1; that pixel uses `raddr` = 0; the next pixel uses `raddr` = 1.
- **Reset in WAIT.** Stimulus: assert `rst_i` for 1 cycle during WAIT. Required: next cycle state is IDLE; `fg_valid` = 0; `first_frame` = 1; `frame_cnt` = 0; `pix_ready` = 1 the following cycle.
